dcache_ram_if: RTL and testbench

//  Bridge between the DCache miss/replace port and a single-word, ack-based memory bus.

---
 rtl/dcache_ram_if_pkg.sv | 16 +
 rtl/dcache_ram_if.sv | 117 +++++++++++
 tb/tb_dcache_ram_if.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ram_if_pkg.sv
// Shared widths, cache-line geometry and FSM state type for the DCache memory bridge.
package dcache_ram_if_pkg;

  localparam int RV32_ADDR_WIDTH   = 32;
  localparam int WORD_WIDTH        = 32;
  localparam int CACHE_LINE_WORDS  = 4;
  localparam int CACHE_LINE_OFFSET = 4;
  localparam int BEAT_WIDTH        = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_ram_if.sv
// Turns DCache line write-backs and refills into 4-beat word bursts on an ack-based bus.
// Write-back wins over a simultaneous refill; refill words return one cycle after each ack.
module dcache_ram_if
  import dcache_ram_if_pkg::*;
#(
  parameter int ADDR_WIDTH = RV32_ADDR_WIDTH,
  parameter int DATA_WIDTH = WORD_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ram_rd_req_i,
  input  logic [ADDR_WIDTH-1:0]                ram_rd_addr_i,
  output logic                                 ram_rd_rdy_o,
  output logic [DATA_WIDTH-1:0]                ram_rd_data_o,
  output logic                                 ram_rd_valid_o,
  output logic [2:0]                           ram_rd_num_o,
  input  logic                                 ram_wr_req_i,
  input  logic [ADDR_WIDTH-1:0]                ram_wr_addr_i,
  input  logic [CACHE_LINE_WORDS*DATA_WIDTH-1:0] ram_wr_data_i,
  output logic                                 ram_wr_rdy_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
  input  logic                                 mem_ack_i
);

  state_e                                      r_state;
  state_e                                      w_state_nxt;
  logic [BEAT_WIDTH-1:0]                       r_beat;
  logic [BEAT_WIDTH-1:0]                       w_beat_nxt;
  logic [ADDR_WIDTH-CACHE_LINE_OFFSET-1:0]     r_line_addr;
  logic [CACHE_LINE_WORDS-1:0][DATA_WIDTH-1:0] r_line;
  logic                                        r_rd_valid;
  logic [2:0]                                  r_rd_num;
  logic [DATA_WIDTH-1:0]                       r_rd_data;
  logic                                        w_wr_acc;
  logic                                        w_rd_acc;
  logic                                        w_rd_beat_done;
  logic                                        w_unused_addr_bits;

  assign w_unused_addr_bits = ^{ram_rd_addr_i[CACHE_LINE_OFFSET-1:0],
                                ram_wr_addr_i[CACHE_LINE_OFFSET-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_wr_acc    = 1'b0;
    w_rd_acc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ram_wr_req_i) begin
          w_wr_acc    = 1'b1;
          w_state_nxt = ST_WR_BURST;
          w_beat_nxt  = '0;
        end else if (ram_rd_req_i) begin
          w_rd_acc    = 1'b1;
          w_state_nxt = ST_RD_BURST;
          w_beat_nxt  = '0;
        end
      end
      ST_WR_BURST, ST_RD_BURST: begin
        if (mem_ack_i) begin
          w_beat_nxt = r_beat + 2'd1;
          if (r_beat == 2'd3) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_rd_beat_done = (r_state == ST_RD_BURST) && mem_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_addr <= '0;
      r_line      <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_num    <= 3'd0;
      r_rd_data   <= '0;
    end else begin
      if (w_wr_acc) begin
        r_line_addr <= ram_wr_addr_i[ADDR_WIDTH-1:CACHE_LINE_OFFSET];
        r_line      <= ram_wr_data_i;
      end else if (w_rd_acc) begin
        r_line_addr <= ram_rd_addr_i[ADDR_WIDTH-1:CACHE_LINE_OFFSET];
      end
      // Refill words are numbered 1..4 so the DCache can leave REFILL on num==4.
      r_rd_valid <= w_rd_beat_done;
      r_rd_num   <= w_rd_beat_done ? ({1'b0, r_beat} + 3'd1) : 3'd0;
      if (w_rd_beat_done) r_rd_data <= mem_rdata_i;
    end
  end

  assign ram_wr_rdy_o   = (r_state == ST_IDLE);
  assign ram_rd_rdy_o   = (r_state == ST_IDLE) && !ram_wr_req_i;
  assign ram_rd_valid_o = r_rd_valid;
  assign ram_rd_num_o   = r_rd_num;
  assign ram_rd_data_o  = r_rd_data;

  assign mem_req_o   = (r_state != ST_IDLE);
  assign mem_we_o    = (r_state == ST_WR_BURST);
  assign mem_addr_o  = {r_line_addr, r_beat, 2'b00};
  assign mem_wdata_o = r_line[r_beat];

endmodule

// File: tb/tb_dcache_ram_if.sv
// Directed bench for dcache_ram_if: refill, write-back, arbitration, back-to-back and reset cases.
module tb_dcache_ram_if;

  logic         clk = 1'b0;
  logic         rst;
  logic         ram_rd_req_i;
  logic [31:0]  ram_rd_addr_i;
  logic         ram_rd_rdy_o;
  logic [31:0]  ram_rd_data_o;
  logic         ram_rd_valid_o;
  logic [2:0]   ram_rd_num_o;
  logic         ram_wr_req_i;
  logic [31:0]  ram_wr_addr_i;
  logic [127:0] ram_wr_data_i;
  logic         ram_wr_rdy_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic [31:0]  mem_rdata_i;
  logic         mem_ack_i;

  dcache_ram_if dut (
    .clk            (clk),
    .rst            (rst),
    .ram_rd_req_i   (ram_rd_req_i),
    .ram_rd_addr_i  (ram_rd_addr_i),
    .ram_rd_rdy_o   (ram_rd_rdy_o),
    .ram_rd_data_o  (ram_rd_data_o),
    .ram_rd_valid_o (ram_rd_valid_o),
    .ram_rd_num_o   (ram_rd_num_o),
    .ram_wr_req_i   (ram_wr_req_i),
    .ram_wr_addr_i  (ram_wr_addr_i),
    .ram_wr_data_i  (ram_wr_data_i),
    .ram_wr_rdy_o   (ram_wr_rdy_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
  } txn_t;
  txn_t log_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land just after the edge, clear of it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wr_words [4];
  logic        rd_accepted;

  initial begin
    wr_words[0] = 32'h1111_1111;
    wr_words[1] = 32'h2222_2222;
    wr_words[2] = 32'h3333_3333;
    wr_words[3] = 32'h4444_4444;

    rst = 1'b1; ram_rd_req_i = 1'b0; ram_rd_addr_i = '0; ram_wr_req_i = 1'b0;
    ram_wr_addr_i = '0; ram_wr_data_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_wr_rdy", ram_wr_rdy_o, 1);
    check("rst_rd_rdy", ram_rd_rdy_o, 1);
    check("rst_valid", ram_rd_valid_o, 0);
    check("rst_num", ram_rd_num_o, 0);
    check("rst_data", ram_rd_data_o, 0);

    // Refill at 0x1234 with back-to-back acks.
    ram_rd_req_i = 1'b1; ram_rd_addr_i = 32'h0000_1234;
    #1; check("t1_rd_rdy", ram_rd_rdy_o, 1);
    step(); ram_rd_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = 1'b1; mem_rdata_i = 32'hA0 + i;
      #1;
      check("t1_req", mem_req_o, 1);
      check("t1_we", mem_we_o, 0);
      check("t1_addr", mem_addr_o, 32'h1230 + 4 * i);
      step();
      check("t1_valid", ram_rd_valid_o, 1);
      check("t1_num", ram_rd_num_o, i + 1);
      check("t1_data", ram_rd_data_o, 32'hA0 + i);
    end
    mem_ack_i = 1'b0;
    #1; check("t1_idle_req", mem_req_o, 0);
    step();
    check("t1_valid_off", ram_rd_valid_o, 0);
    check("t1_num_off", ram_rd_num_o, 0);

    // Write-back at 0x8000_0040, ack every third cycle.
    ram_wr_req_i = 1'b1; ram_wr_addr_i = 32'h8000_0040;
    ram_wr_data_i = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    #1; check("t2_wr_rdy", ram_wr_rdy_o, 1);
    step(); ram_wr_req_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 3; c++) begin
        mem_ack_i = (c == 2);
        #1;
        check("t2_req", mem_req_o, 1);
        check("t2_we", mem_we_o, 1);
        check("t2_addr", mem_addr_o, 32'h8000_0040 + 4 * b);
        check("t2_wdata", mem_wdata_o, wr_words[b]);
        check("t2_wr_rdy", ram_wr_rdy_o, 0);
        step();
      end
    end
    mem_ack_i = 1'b0;
    #1;
    check("t2_done_req", mem_req_o, 0);
    check("t2_done_rdy", ram_wr_rdy_o, 1);

    // Simultaneous refill and write-back: write burst must reach memory first.
    log_q.delete();
    ram_rd_req_i = 1'b1; ram_rd_addr_i = 32'h0000_2000;
    ram_wr_req_i = 1'b1; ram_wr_addr_i = 32'h0000_3000;
    ram_wr_data_i = 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000;
    #1;
    check("t3_rd_rdy_blk", ram_rd_rdy_o, 0);
    check("t3_wr_rdy", ram_wr_rdy_o, 1);
    step(); ram_wr_req_i = 1'b0;
    mem_ack_i = 1'b1;
    for (int c = 0; c < 20 && log_q.size() < 8; c++) begin
      mem_rdata_i = 32'hC0 + c;
      #1;
      if (mem_req_o && mem_ack_i) log_q.push_back('{we: mem_we_o, addr: mem_addr_o});
      rd_accepted = ram_rd_req_i && ram_rd_rdy_o;
      step();
      if (rd_accepted) ram_rd_req_i = 1'b0;
    end
    mem_ack_i = 1'b0;
    check("t3_nbeats", log_q.size(), 8);
    check("t3_rd_taken", ram_rd_req_i, 0);
    for (int k = 0; k < 8; k++) begin
      if (k < log_q.size()) begin
        check("t3_order_we", log_q[k].we, (k < 4) ? 1 : 0);
        check("t3_order_addr", log_q[k].addr,
              (k < 4) ? (32'h3000 + 4 * k) : (32'h2000 + 4 * (k - 4)));
      end
    end
    step();

    // New refill accepted in the very cycle num==4 is presented.
    ram_rd_req_i = 1'b1; ram_rd_addr_i = 32'h0000_0100;
    #1; step(); ram_rd_req_i = 1'b0;
    mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata_i = 32'hB0 + i;
      step();
    end
    mem_ack_i = 1'b0;
    ram_rd_req_i = 1'b1; ram_rd_addr_i = 32'h0000_0208;
    #1;
    check("t4_num4", ram_rd_num_o, 4);
    check("t4_valid4", ram_rd_valid_o, 1);
    check("t4_data4", ram_rd_data_o, 32'hB3);
    check("t4_rd_rdy", ram_rd_rdy_o, 1);
    step(); ram_rd_req_i = 1'b0;
    #1;
    check("t4_nogap_req", mem_req_o, 1);
    check("t4_nogap_addr", mem_addr_o, 32'h0000_0200);
    mem_ack_i = 1'b1;
    repeat (4) step();
    mem_ack_i = 1'b0;
    step();

    // Reset after the second refill ack aborts the burst.
    ram_rd_req_i = 1'b1; ram_rd_addr_i = 32'h0000_0400;
    #1; step(); ram_rd_req_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55;
    step(); step();
    check("t5_num2", ram_rd_num_o, 2);
    mem_ack_i = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    #1;
    check("t5_req", mem_req_o, 0);
    check("t5_valid", ram_rd_valid_o, 0);
    check("t5_num", ram_rd_num_o, 0);
    check("t5_data", ram_rd_data_o, 0);
    check("t5_rd_rdy", ram_rd_rdy_o, 1);
    check("t5_wr_rdy", ram_wr_rdy_o, 1);
    mem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; check("t5_no_beat", mem_req_o, 0);
      step();
      check("t5_no_valid", ram_rd_valid_o, 0);
    end
    mem_ack_i = 1'b0;

    // Stray ack while idle must not move the beat counter.
    mem_ack_i = 1'b1; mem_rdata_i = 32'hEE;
    step();
    mem_ack_i = 1'b0;
    check("t6_valid", ram_rd_valid_o, 0);
    check("t6_num", ram_rd_num_o, 0);
    ram_rd_req_i = 1'b1; ram_rd_addr_i = 32'h0000_0500;
    #1; step(); ram_rd_req_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    #1; check("t6_first_addr", mem_addr_o, 32'h0000_0500);
    step();
    check("t6_first_num", ram_rd_num_o, 1);
    check("t6_first_data", ram_rd_data_o, 32'h77);
    repeat (3) step();
    mem_ack_i = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
